// File: rtl/serpent_pkg.sv
// Shared Serpent definitions: FSM states, round count, linear
// transform rotations and S-box tables S0-S7 (also used by the decryptor).
package serpent_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam int NUM_ROUNDS_DEF = 32;

    localparam int unsigned LT_ROT0 = 13;
    localparam int unsigned LT_ROT2 = 3;
    localparam int unsigned LT_SHL0 = 3;
    localparam int unsigned LT_ROT1 = 1;
    localparam int unsigned LT_ROT3 = 7;
    localparam int unsigned LT_SHL1 = 7;
    localparam int unsigned LT_ROT4 = 5;
    localparam int unsigned LT_ROT5 = 22;

    // SBOX_TAB[s] holds 16 nibbles; entry i sits at bits [4*i +: 4]
    localparam logic [7:0][63:0] SBOX_TAB = {
        64'h6539AC47B28E0FD1,
        64'h0A3DF19EB6485C27,
        64'h176D8E30C9A4B25F,
        64'hD7E9A4526B0C38F1,
        64'hE57A421D369C8BF0,
        64'h25B04E1DFAC39768,
        64'h43D68EB1A50972CF,
        64'hC90724DEB56A1F83
    };

    function automatic logic [3:0] sbox(
        input logic [2:0] idx,
        input logic [3:0] x
    );
        return SBOX_TAB[idx][{x, 2'b00} +: 4];
    endfunction

    function automatic logic [31:0] rotl(
        input logic [31:0] x,
        input int unsigned n
    );
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/serpent_encrypt_stage.sv
// One Serpent round after key mixing: bitsliced S-box then
// linear transform (bypassed in the last round).
module serpent_encrypt_stage
    import serpent_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic [5:0]  round,
    output logic [31:0] y0,
    output logic [31:0] y1,
    output logic [31:0] y2,
    output logic [31:0] y3
);

    localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);

    logic [31:0] s0, s1, s2, s3;
    logic [31:0] a, b, c, d;

    always_comb begin
        s0 = '0;
        s1 = '0;
        s2 = '0;
        s3 = '0;
        for (int j = 0; j < 32; j++) begin
            {s3[j], s2[j], s1[j], s0[j]} =
                sbox(round[2:0], {x3[j], x2[j], x1[j], x0[j]});
        end
    end

    always_comb begin
        a = rotl(s0, LT_ROT0);
        c = rotl(s2, LT_ROT2);
        b = s1 ^ a ^ c;
        d = s3 ^ c ^ (a << LT_SHL0);
        b = rotl(b, LT_ROT1);
        d = rotl(d, LT_ROT3);
        a = a ^ b ^ d;
        c = c ^ d ^ (b << LT_SHL1);
        a = rotl(a, LT_ROT4);
        c = rotl(c, LT_ROT5);
    end

    always_comb begin
        if (round == LAST) begin
            {y3, y2, y1, y0} = {s3, s2, s1, s0};
        end else begin
            {y3, y2, y1, y0} = {d, c, b, a};
        end
    end

endmodule

// File: rtl/serpent_encrypt.sv
// Iterative Serpent encryptor, one round per cycle, subkeys fetched by index.
// Define SERPENT_ENC_BUSY_EN to add the o_busy output.
module serpent_encrypt
    import serpent_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_en,
    input  logic         i_subkey_valid,
    input  logic [127:0] i_key,
    input  logic [127:0] i_data,
`ifdef SERPENT_ENC_BUSY_EN
    output logic         o_busy,
`endif
    output logic [127:0] o_data,
    output logic [5:0]   o_address,
    output logic         o_data_valid
);

    localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] FIN  = 6'(NUM_ROUNDS);

    state_t      state, state_nxt;
    logic [5:0]  rnd;
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] y0, y1, y2, y3;
    logic        start;

    serpent_encrypt_stage #(
        .NUM_ROUNDS(NUM_ROUNDS)
    ) u_stage (
        .x0   (w0 ^ i_key[31:0]),
        .x1   (w1 ^ i_key[63:32]),
        .x2   (w2 ^ i_key[95:64]),
        .x3   (w3 ^ i_key[127:96]),
        .round(rnd),
        .y0   (y0),
        .y1   (y1),
        .y2   (y2),
        .y3   (y3)
    );

    always_comb begin
        state_nxt = state;
        o_address = '0;
        start     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                start = i_en & i_subkey_valid;
                if (start) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                o_address = rnd;
                if (rnd == LAST) state_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                o_address = FIN;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            rnd          <= '0;
            w0           <= '0;
            w1           <= '0;
            w2           <= '0;
            w3           <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            o_data_valid <= 1'b0;
            if (start) begin
                {w3, w2, w1, w0} <= i_data;
                rnd              <= '0;
            end
            if (state == ST_ROUND) begin
                {w3, w2, w1, w0} <= {y3, y2, y1, y0};
                rnd              <= rnd + 6'd1;
            end
            if (state == ST_FINAL) begin
                o_data       <= {w3, w2, w1, w0} ^ i_key;
                o_data_valid <= 1'b1;
            end
        end
    end

`ifdef SERPENT_ENC_BUSY_EN
    assign o_busy = (state != ST_IDLE);
`endif

endmodule

// File: tb/tb_serpent_encrypt.sv
// Testbench for serpent_encrypt against a reference Serpent model.
module tb_serpent_encrypt;

    localparam int NR = 32;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic         kv;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] dout;
    logic [5:0]   addr;
    logic         dv;
`ifdef SERPENT_ENC_BUSY_EN
    logic         busy;
`endif

    logic [127:0] keys [64];
    int checks = 0;
    int errors = 0;

    int SB [8][16] = '{
        '{3, 8, 15, 1, 10, 6, 5, 11, 14, 13, 4, 2, 7, 0, 9, 12},
        '{15, 12, 2, 7, 9, 0, 5, 10, 1, 11, 14, 8, 6, 13, 3, 4},
        '{8, 6, 7, 9, 3, 12, 10, 15, 13, 1, 14, 4, 0, 11, 5, 2},
        '{0, 15, 11, 8, 12, 9, 6, 3, 13, 1, 2, 4, 10, 7, 5, 14},
        '{1, 15, 8, 3, 12, 0, 11, 6, 2, 5, 4, 10, 9, 14, 7, 13},
        '{15, 5, 2, 11, 4, 10, 9, 12, 0, 3, 14, 8, 13, 6, 7, 1},
        '{7, 2, 12, 5, 8, 4, 6, 11, 14, 9, 1, 15, 13, 3, 10, 0},
        '{1, 13, 15, 0, 14, 8, 2, 11, 7, 4, 12, 10, 9, 3, 5, 6}
    };
    int IS [8][16];

    always #5 clk = ~clk;

    assign key = keys[addr];

    serpent_encrypt dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_en          (en),
        .i_subkey_valid(kv),
        .i_key         (key),
        .i_data        (din),
`ifdef SERPENT_ENC_BUSY_EN
        .o_busy        (busy),
`endif
        .o_data        (dout),
        .o_address     (addr),
        .o_data_valid  (dv)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] sbox_layer(input logic [127:0] s,
                                                input int box, input bit inv);
        logic [127:0] o;
        logic [3:0]   nib;
        int           v;
        o = '0;
        for (int j = 0; j < 32; j++) begin
            nib = {s[96+j], s[64+j], s[32+j], s[j]};
            v = inv ? IS[box][nib] : SB[box][nib];
            o[j]    = v[0];
            o[32+j] = v[1];
            o[64+j] = v[2];
            o[96+j] = v[3];
        end
        return o;
    endfunction

    function automatic logic [127:0] lt(input logic [127:0] s);
        logic [31:0] a, b, c, d;
        {d, c, b, a} = s;
        a = rol(a, 13);
        c = rol(c, 3);
        b = b ^ a ^ c;
        d = d ^ c ^ (a << 3);
        b = rol(b, 1);
        d = rol(d, 7);
        a = a ^ b ^ d;
        c = c ^ d ^ (b << 7);
        a = rol(a, 5);
        c = rol(c, 22);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] inv_lt(input logic [127:0] s);
        logic [31:0] a, b, c, d;
        {d, c, b, a} = s;
        c = rol(c, 32 - 22);
        a = rol(a, 32 - 5);
        c = c ^ d ^ (b << 7);
        a = a ^ b ^ d;
        d = rol(d, 32 - 7);
        b = rol(b, 32 - 1);
        d = d ^ c ^ (a << 3);
        b = b ^ a ^ c;
        c = rol(c, 32 - 3);
        a = rol(a, 32 - 13);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [127:0] s;
        s = pt;
        for (int r = 0; r < NR; r++) begin
            s = sbox_layer(s ^ keys[r], r % 8, 1'b0);
            if (r != NR - 1) s = lt(s);
        end
        return s ^ keys[NR];
    endfunction

    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [127:0] s;
        s = ct ^ keys[NR];
        for (int r = NR - 1; r >= 0; r--) begin
            if (r != NR - 1) s = inv_lt(s);
            s = sbox_layer(s, r % 8, 1'b1) ^ keys[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_block(input logic [127:0] pt, input bit drop_kv,
                             output logic [127:0] ct, output int lat,
                             output bit addr_ok);
        int ea;
        en  = 1'b1;
        kv  = 1'b1;
        din = pt;
        @(posedge clk); #1;
        en  = 1'b0;
        din = rnd128();
        if (drop_kv) kv = 1'b0;
        addr_ok = (addr == 6'd0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            ea = (k <= 31) ? k : ((k == 32) ? 32 : 0);
            if (addr != 6'(ea)) addr_ok = 1'b0;
            if (dv) begin
                lat = k;
                break;
            end
            din = rnd128();
            en  = 1'($urandom % 2);
        end
        en = 1'b0;
        kv = 1'b1;
        ct = dout;
    endtask

    initial begin
        vec_t         tbl [6];
        logic [127:0] ct;
        int           lat;
        bit           aok;
        int           pulses;
        logic [127:0] d [68];
        int           pe [$];
        logic [127:0] cts [$];

        for (int b = 0; b < 8; b++)
            for (int v = 0; v < 16; v++)
                IS[b][SB[b][v]] = v;
        for (int i = 0; i < 64; i++) keys[i] = '0;

        rstn = 1'b0;
        en   = 1'b0;
        kv   = 1'b0;
        din  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_data", dout, '0);
        chk("reset_valid", 128'(dv), 128'(0));
        chk("reset_addr", 128'(addr), 128'(0));
`ifdef SERPENT_ENC_BUSY_EN
        chk("reset_busy", 128'(busy), 128'(0));
`endif
        @(negedge clk);
        rstn = 1'b1;

        // zero key, zero plaintext, with address trace and pulse width
        run_block('0, 1'b0, ct, lat, aok);
        chk("zero_ct", ct, model_enc('0));
        chk("zero_latency", 128'(lat), 128'(33));
        chk("addr_trace", 128'(aok), 128'(1));
        @(posedge clk); #1;
        chk("valid_one_cycle", 128'(dv), 128'(0));
        chk("data_held", dout, ct);

        for (int i = 0; i <= NR; i++) keys[i] = rnd128();
        tbl[0].pt = 128'h0123456789ABCDEFFEDCBA9876543210;
        tbl[1].pt = '1;
        for (int i = 2; i < 6; i++) tbl[i].pt = rnd128();
        for (int i = 0; i < 6; i++) tbl[i].exp = model_enc(tbl[i].pt);

        for (int i = 0; i < 6; i++) begin
            run_block(tbl[i].pt, i == 3, ct, lat, aok);
            chk($sformatf("vec%0d_ct", i), ct, tbl[i].exp);
            chk($sformatf("vec%0d_dec", i), model_dec(ct), tbl[i].pt);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(33));
        end

        // start request without loaded subkeys
        en = 1'b1;
        kv = 1'b0;
        din = rnd128();
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (dv || addr != 6'd0) pulses++;
        end
        chk("no_start_without_kv", 128'(pulses), 128'(0));
        tbl[0].pt = rnd128();
        run_block(tbl[0].pt, 1'b0, ct, lat, aok);
        chk("kv_start_latency", 128'(lat), 128'(33));
        chk("kv_start_ct", ct, model_enc(tbl[0].pt));

        // reset in the middle of a block
        en = 1'b1;
        kv = 1'b1;
        din = rnd128();
        @(posedge clk); #1;
        en = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("mid_addr", 128'(addr), 128'(15));
`ifdef SERPENT_ENC_BUSY_EN
        chk("mid_busy", 128'(busy), 128'(1));
`endif
        rstn = 1'b0;
        #1;
        chk("abort_data", dout, '0);
        chk("abort_valid", 128'(dv), 128'(0));
        chk("abort_addr", 128'(addr), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dv) pulses++;
        end
        chk("abort_no_pulse", 128'(pulses), 128'(0));
        tbl[1].pt = rnd128();
        run_block(tbl[1].pt, 1'b0, ct, lat, aok);
        chk("restart_ct", ct, model_enc(tbl[1].pt));

        // continuous request: back-to-back blocks
        en = 1'b1;
        kv = 1'b1;
        for (int m = 0; m < 68; m++) begin
            d[m] = rnd128();
            din = d[m];
            @(posedge clk); #1;
            if (dv) begin
                pe.push_back(m);
                cts.push_back(dout);
            end
        end
        en = 1'b0;
        chk("b2b_pulses", 128'(pe.size()), 128'(2));
        if (pe.size() == 2) begin
            chk("b2b_first_edge", 128'(pe[0]), 128'(33));
            chk("b2b_gap", 128'(pe[1] - pe[0]), 128'(34));
            chk("b2b_ct0", cts[0], model_enc(d[0]));
            chk("b2b_ct1", cts[1], model_enc(d[34]));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/serpent_encrypt.md
SERPENT_ENCRYPT -- requirements
Module: serpent_encrypt

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 32, number of S-box rounds; the final subkey index equals NUM_ROUNDS.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_en, input, 1, start request; it is sampled only in IDLE.
REQ-005 SHALL have port i_subkey_valid, input, 1, high when the subkey memory is loaded.
REQ-006 SHALL have port i_key, input, 128, the subkey addressed by o_address, valid in the same cycle (asynchronous-read key store).
REQ-007 SHALL have port i_data, input, 128, plaintext; word0 = [31:0] through word3 = [127:96].
REQ-008 SHALL have port o_data, output, 128, ciphertext, using the same word packing as i_data.
REQ-009 SHALL have port o_address, output, 6, the subkey index currently required.
REQ-010 SHALL have port o_data_valid, output, 1, one-cycle completion pulse.

Function
REQ-011 SHALL implement the FSM states IDLE, ROUND and FINAL, with one-hot-free 2-bit encoding.
REQ-012 IDLE: o_address = 0; if i_en & i_subkey_valid, latch i_data into the word registers, clear the round counter and go to ROUND; otherwise stay in IDLE.
REQ-013 ROUND, per cycle: words <= stage(words ^ i_key, round).
- stage applies S-box S[round mod 8] bitsliced, then the Serpent linear transform.
- The linear transform is skipped when round == NUM_ROUNDS-1.
REQ-014 ROUND: o_address = round; the counter increments each cycle; after round NUM_ROUNDS-1 the FSM goes to FINAL.
REQ-015 FINAL: o_address = NUM_ROUNDS; o_data <= words ^ i_key; o_data_valid <= 1; go to IDLE.
REQ-016 Latency: for acceptance at edge T, o_data_valid SHALL be high for exactly the cycle after edge T+NUM_ROUNDS+1 (T+33 by default).
REQ-017 o_data SHALL hold its value until the next FINAL; o_data_valid SHALL be high for exactly one cycle per block.
REQ-018 i_en and i_data SHALL be ignored outside IDLE; a request held continuously starts the next block in the cycle after FINAL.
REQ-019 If i_subkey_valid falls mid-operation, the block SHALL still complete; i_subkey_valid gates only the start.
REQ-020 All XOR and S-box operations SHALL be 32-bit wordwise; the linear transform rotations are modulo 32; there SHALL be no carries.

Reset
REQ-021 On i_rstn low, the FSM SHALL go to IDLE immediately.
REQ-022 On i_rstn low, the following SHALL clear to 0: round counter, word registers, o_data and o_data_valid.
REQ-023 A reset asserted mid-block SHALL abort the block with no o_data_valid pulse.
REQ-024 After reset release, the first acceptance SHALL occur no earlier than the first edge with i_en & i_subkey_valid.

Configuration
REQ-025 Macro SERPENT_ENC_BUSY_EN SHALL control an extra busy output.
- Defined: adds output o_busy (1 bit), high in ROUND and FINAL, 0 in reset.
- Undefined: the port is absent and behaviour is otherwise identical.

Structure
REQ-026 A shared package serpent_pkg SHALL hold:
- the state encodings;
- the NUM_ROUNDS default;
- the linear transform rotation constants;
- the S-box tables S0-S7, shared with the decryptor's inverse tables file.
REQ-027 The combinational round logic SHALL be a single sub-module, serpent_encrypt_stage.
- Inputs: four 32-bit words and the 6-bit round.
- Outputs: four 32-bit words.

Verification
REQ-028 Zero key, zero plaintext, start pulse: o_data_valid is high exactly 33 cycles after acceptance, and o_data equals the golden-model ciphertext.
REQ-029 Random key and plaintext 0x0123456789ABCDEFFEDCBA9876543210: o_data equals the golden model; feeding it to the decryptor returns the plaintext.
REQ-030 o_address trace: a start gives 0 during IDLE, then 0,1,...,31 in ROUND, 32 in FINAL, then 0.
REQ-031 i_en high without i_subkey_valid for 10 cycles: there is no start and o_data_valid stays 0; raising i_subkey_valid gives acceptance on the next edge.
REQ-032 i_rstn asserted at round 15: all outputs read 0 immediately and no valid pulse occurs; a restart then produces the correct ciphertext.
REQ-033 i_en held high continuously: back-to-back valid pulses 34 cycles apart; i_data changes mid-block do not alter that block's o_data.
